// File: rtl/bus_copy_master_if.sv
// bus_copy_master_if: memory-mapped data bus between
// the copy master and the address decoder.
interface bus_copy_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              WR;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output address, WR, wdata,
    input  rdata
  );

  modport slave (
    input  address, WR, wdata,
    output rdata
  );
endinterface

// File: rtl/bus_copy_master.sv
// bus_copy_master: block copy initiator on the data bus.
// BUS_COPY_BOUNDS_CHECK_EN stops on accesses >= MAP_TOP.
module bus_copy_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int RD_LAT  = 1,
  parameter int MAP_TOP = 768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  bus_copy_master_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, RD, WR, DONE
  } state_t;

`ifdef BUS_COPY_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [ADDR_W:0] TOP =
    (ADDR_W+1)'(MAP_TOP);
  localparam logic [2:0] LAST =
    3'(RD_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  index;
  logic [2:0]        lat;

  logic [LEN_W-1:0]  nxt;
  logic [ADDR_W-1:0] wr_a;
  logic [ADDR_W-1:0] rd_n;
  logic              bad_go;
  logic              bad_wr;
  logic              bad_rd;

  assign nxt  = index + 1'b1;
  assign wr_a = dst + ADDR_W'(index);
  assign rd_n = src + ADDR_W'(nxt);

  // Checks look at the address the next cycle would drive.
  assign bad_go = CHK && ({1'b0, src_base} >= TOP);
  assign bad_wr = CHK && ({1'b0, wr_a} >= TOP);
  assign bad_rd = CHK && ({1'b0, rd_n} >= TOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.address <= '0;
      bus.WR      <= 1'b0;
      bus.wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      src         <= '0;
      dst         <= '0;
      cnt         <= '0;
      index       <= '0;
      lat         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            src   <= src_base;
            dst   <= dst_base;
            cnt   <= len;
            index <= '0;
            lat   <= '0;
            err   <= 1'b0;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (bad_go) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state       <= RD;
              busy        <= 1'b1;
              bus.address <= src_base;
            end
          end
        end
        RD: begin
          if (lat != LAST) begin
            lat <= lat + 1'b1;
          end else if (bad_wr) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
            bus.address <= '0;
          end else begin
            state       <= WR;
            bus.address <= wr_a;
            bus.WR      <= 1'b1;
            bus.wdata   <= bus.rdata;
          end
        end
        WR: begin
          bus.WR <= 1'b0;
          index  <= nxt;
          lat    <= '0;
          if (nxt == cnt) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            bus.address <= '0;
          end else if (bad_rd) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
            bus.address <= '0;
          end else begin
            state       <= RD;
            bus.address <= rd_n;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_copy_master.sv
// tb_bus_copy_master: two DUTs (RD_LAT 1 and 3) on shared
// stimulus, each with a cycle-trace scoreboard.
module tb_bus_copy_master;
  typedef struct packed {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
  } ent_t;

`ifdef BUS_COPY_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic [1:0]  idle_v;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h",
               nm, d, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = 1 + 2 * g;

    bus_copy_master_if bus ();
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] ad [0:3];

    bus_copy_master #(
      .ADDR_W(32), .DATA_W(32), .LEN_W(16),
      .RD_LAT(L), .MAP_TOP(768)
    ) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_base(src), .dst_base(dst), .len(len),
      .busy(busy), .done(done), .err(err),
      .bus(bus)
    );

    // Slave model: data is address+0x100, seen L cycles late.
    always @(posedge clk) begin
      ad[0] <= bus.address;
      for (int i = 1; i < 4; i++) ad[i] <= ad[i-1];
    end
    assign bus.rdata =
      ((L == 1) ? bus.address : ad[(L > 1) ? L - 2 : 0])
      + 32'h100;

    ent_t tr[$];
    int   n       = 0;
    int   busy_lo = 0;
    int   done_at = -10;
    bit   errf    = 1'b0;

    assign idle_v[g] = (n >= done_at + 2);

    // Reference: expected bus trace per accepted start.
    always @(posedge clk) begin
      n++;
      if (rst) begin
        tr.delete();
        busy_lo = 0;
        done_at = -10;
        errf    = 1'b0;
      end else if (start && n >= done_at + 2) begin
        int          t;
        bit          b;
        logic [31:0] ra;
        logic [31:0] wa;
        t = 0;
        b = 1'b0;
        tr.delete();
        for (int i = 0; i < int'(len); i++) begin
          ra = src + i;
          if (CHK && ra >= 768) begin b = 1'b1; break; end
          for (int c = 0; c < L; c++)
            tr.push_back('{ra, 1'b0, 32'h0});
          t += L;
          wa = dst + i;
          if (CHK && wa >= 768) begin b = 1'b1; break; end
          tr.push_back('{wa, 1'b1, ra + 32'h100});
          t += 1;
        end
        busy_lo = n;
        done_at = n + t;
        errf    = b;
      end
    end

    always @(negedge clk) begin
      if (n > 0) begin
        bit   eb;
        ent_t e;
        eb = (n >= busy_lo) && (n < done_at);
        chk("busy", g, 32'(busy), 32'(eb));
        chk("done", g, 32'(done), 32'(n == done_at));
        chk("err", g, 32'(err),
            32'(errf && n >= done_at));
        if (eb) begin
          if (tr.size() == 0) begin
            chk("trace_underrun", g, 32'd1, 32'd0);
          end else begin
            e = tr.pop_front();
            chk("address", g, bus.address, e.a);
            chk("WR", g, 32'(bus.WR), 32'(e.w));
            if (e.w) chk("wdata", g, bus.wdata, e.d);
          end
        end else begin
          chk("idle_address", g, bus.address, 32'h0);
          chk("idle_WR", g, 32'(bus.WR), 32'h0);
        end
      end
    end
  end

  task automatic go(input logic [31:0] s,
                    input logic [31:0] d,
                    input logic [15:0] l);
    @(negedge clk);
    start = 1'b1;
    src   = s;
    dst   = d;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic settle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (idle_v != 2'b11 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000)
      chk("settle_timeout", 0, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    src   = '0;
    dst   = '0;
    len   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    go(256, 0, 3);
    settle();

    go(100, 200, 0);
    settle();

    go(256, 0, 3);
    @(negedge clk);
    go(512, 0, 5);
    settle();

    go(256, 16, 4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    go(300, 40, 4);
    settle();

    go(766, 0, 4);
    settle();

    go(32'hFFFF_FFFE, 32'hFFFF_FFFF, 3);
    settle();

    for (int k = 0; k < 8; k++) begin
      go($urandom_range(0, 800),
         $urandom_range(0, 800),
         16'($urandom_range(0, 6)));
      settle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Bus initiator for the memory-mapped data bus. It drives address, WR and write data, and reads data back through the decoder's read mux.
- Copies a block of words from a source region to a destination region, for example encrypted image words from the input region into working RAM.
- Sits between the control logic and the address decoder. It is the requesting end of the bus that the decoder answers.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width.
- LEN_W, 16, width of the word-count input.
- RD_LAT, 1, read latency in cycles from address presented to rdata valid (range 1..4).
- MAP_TOP, 768, first address outside the decoded map (0-255, 256-511, 512-767).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a copy.
- src_base  input  ADDR_W  first source address, sampled with start.
- dst_base  input  ADDR_W  first destination address, sampled with start.
- len  input  LEN_W  number of words to copy, sampled with start.
- rdata  input  DATA_W  read data returned from the bus mux.
- address  output  ADDR_W  bus address.
- WR  output  1  bus write strobe.
- wdata  output  DATA_W  bus write data.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- err  output  1  bounds violation flag (see Optional Feature).

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.
- Reset values: address=0, WR=0, wdata=0, busy=0, done=0, err=0, state=IDLE, index=0.
  - rst asserted mid-copy aborts the copy at the next edge.
  - No done pulse is produced on abort.
- All outputs are registered.

States:
- IDLE
  - If start=1: latch src/dst/len, index=0, err=0.
  - If len=0: go to DONE with no bus cycle.
  - Otherwise go to RD with busy=1.
  - start is ignored in every state except IDLE.
- RD
  - address=src+index, WR=0.
  - Held for exactly RD_LAT cycles.
  - rdata is captured into a data register at the edge ending the RD_LAT-th cycle; then go to WR.
- WR
  - address=dst+index, WR=1, wdata=captured data, for exactly one cycle.
  - Then index+1.
  - If index+1==len, go to DONE; else go to RD.
- DONE
  - done=1 and busy=0 for one cycle; address=0, WR=0.
  - Then go to IDLE.

Timing:
- Each word costs RD_LAT+1 cycles.
- If start is sampled at edge k, the first RD cycle is k+1.
- done is asserted in cycle k+1+len*(RD_LAT+1).

Arithmetic and width rules:
- Addresses wrap modulo 2^ADDR_W.
- index is LEN_W bits.
- len = 2^LEN_W-1 is legal.

Bus rules:
- WR is never high outside the WR state.
- address is 0 in IDLE and DONE.

Source/destination overlap:
- Not detected.
- Words are copied strictly in ascending order, one read before each write.

Optional Feature:
- Macro: BUS_COPY_BOUNDS_CHECK_EN.
- When defined:
  - Before each RD or WR cycle, the address to be driven is compared with MAP_TOP.
  - If it is >= MAP_TOP, that cycle is not issued (WR stays 0).
  - err=1 and the block goes to DONE. done still pulses.
  - err holds until the next accepted start or rst.
- When not defined:
  - No check is made; err is tied to 0.
  - Out-of-map accesses are issued as normal.

Test Plan:
- Reset, then idle for 5 cycles: address=0, WR=0, busy=0, done=0, err=0 throughout.
- Basic copy, RD_LAT=1: start with src=256, dst=0, len=3; the bench model returns rdata=address+0x100.
  - Expect writes to 0,1,2 with data 0x200,0x201,0x202.
  - WR high exactly 3 cycles; done in cycle k+7; busy high cycles k+1..k+6.
- Zero length: start with len=0.
  - Expect done in cycle k+1, busy never high, WR never high.
- Start while busy and latency: during the copy above, pulse start with src=512 and len=5; it is ignored and only 3 writes occur.
  - Rerun with RD_LAT=3: done at k+1+3*4=k+13.
- Reset mid-operation: assert rst during the second WR cycle of a len=4 copy.
  - The next cycle shows all outputs at reset values; no done pulse.
  - A new start then works normally.
- Bounds check (BUS_COPY_BOUNDS_CHECK_EN defined): src=766, dst=0, len=4.
  - Expect two words copied, then no access to address 768.
  - err=1 and done pulses once.
  - With the macro undefined: 4 words are copied and err stays 0.
